// File: rtl/riscv_pkg.sv
// Shared types and constants for the Execute-stage integer divide sequencer.
package riscv_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } div_state_t;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] DIV_BY_ZERO_Q = '1;

endpackage

// File: rtl/execute_div_ctrl_if.sv
// Execute-stage <-> divide sequencer signal bundle.
interface execute_div_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  StartE;
    logic [1:0]            DivOpE;
    logic [DATA_WIDTH-1:0] SrcAE;
    logic [DATA_WIDTH-1:0] SrcBE;
    logic                  FlushE;
    logic                  DivStallE;
    logic                  DivBusyE;
    logic                  DivDoneE;
    logic [DATA_WIDTH-1:0] DivResultE;

    modport master (
        output StartE, DivOpE, SrcAE, SrcBE, FlushE,
        input  DivStallE, DivBusyE, DivDoneE, DivResultE
    );

    modport slave (
        input  StartE, DivOpE, SrcAE, SrcBE, FlushE,
        output DivStallE, DivBusyE, DivDoneE, DivResultE
    );
endinterface

// File: rtl/execute_div_ctrl_div_iter_core.sv
// Radix-2 restoring divide datapath: one quotient bit per step on unsigned magnitudes.
module div_iter_core #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  step,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] rem_nxt,
    output logic [DATA_WIDTH-1:0] quo_nxt
);
    logic [DATA_WIDTH-1:0] rem_q;
    logic [DATA_WIDTH-1:0] quo_q;
    logic [DATA_WIDTH-1:0] dvs_q;
    logic [DATA_WIDTH:0]   trial;
    logic [DATA_WIDTH:0]   diff;

    // The shifted partial remainder can reach 2*divisor-1, so the trial needs one extra bit.
    assign trial   = {rem_q, quo_q[DATA_WIDTH-1]};
    assign diff    = trial - {1'b0, dvs_q};
    assign rem_nxt = diff[DATA_WIDTH] ? trial[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
    assign quo_nxt = {quo_q[DATA_WIDTH-2:0], ~diff[DATA_WIDTH]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
        end else if (step) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
        end
    end
endmodule

// File: rtl/execute_div_ctrl.sv
// RV32M DIV/DIVU/REM/REMU sequencer in E: FSM, iteration counter, sign and special-case handling.
module execute_div_ctrl
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    execute_div_ctrl_if.slave     div_if
);
    div_state_t            state;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  neg_res;
    logic                  is_rem;
    logic                  done_q;
    logic [DATA_WIDTH-1:0] result_q;

    logic                  accept;
    logic                  is_signed;
    logic signed [DATA_WIDTH-1:0] src_a_s;
    logic signed [DATA_WIDTH-1:0] src_b_s;
    logic                  a_neg;
    logic                  b_neg;
    logic [DATA_WIDTH-1:0] a_mag;
    logic [DATA_WIDTH-1:0] b_mag;
    logic                  div_zero;
    logic                  overflow;
    logic                  special;
    logic [DATA_WIDTH-1:0] special_res;
    logic [DATA_WIDTH-1:0] rem_nxt;
    logic [DATA_WIDTH-1:0] quo_nxt;

    function automatic logic [DATA_WIDTH-1:0] apply_sign(input logic [DATA_WIDTH-1:0] mag,
                                                         input logic neg);
        return neg ? -mag : mag;
    endfunction

    assign accept    = (state == IDLE) && div_if.StartE && !div_if.FlushE;
    assign is_signed = !div_if.DivOpE[0];
    assign src_a_s   = div_if.SrcAE;
    assign src_b_s   = div_if.SrcBE;
    assign a_neg     = is_signed && (src_a_s < 0);
    assign b_neg     = is_signed && (src_b_s < 0);
    assign a_mag     = a_neg ? -div_if.SrcAE : div_if.SrcAE;
    assign b_mag     = b_neg ? -div_if.SrcBE : div_if.SrcBE;
    assign div_zero  = (div_if.SrcBE == '0);
    assign overflow  = is_signed && (div_if.SrcAE == {1'b1, {(DATA_WIDTH-1){1'b0}}})
                                 && (div_if.SrcBE == '1);
    assign special   = div_zero || overflow;

    // Divide-by-zero and signed overflow bypass the iteration and finish in one cycle.
    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = div_if.DivOpE[1] ? div_if.SrcAE : DATA_WIDTH'(DIV_BY_ZERO_Q);
        else
            special_res = div_if.DivOpE[1] ? '0 : div_if.SrcAE;
    end

    div_iter_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept && !special),
        .step     ((state == CALC) && !div_if.FlushE),
        .dividend (a_mag),
        .divisor  (b_mag),
        .rem_nxt  (rem_nxt),
        .quo_nxt  (quo_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            neg_res  <= 1'b0;
            is_rem   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        is_rem  <= div_if.DivOpE[1];
                        neg_res <= div_if.DivOpE[1] ? a_neg : (a_neg ^ b_neg);
                        if (special) begin
                            result_q <= special_res;
                            done_q   <= 1'b1;
                            state    <= DONE;
                        end else begin
                            cnt   <= CNT_WIDTH'(DATA_WIDTH);
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (div_if.FlushE) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_WIDTH'(1);
                        // Final step: register the sign-corrected result from this step's outputs.
                        if (cnt == CNT_WIDTH'(1)) begin
                            result_q <= apply_sign(is_rem ? rem_nxt : quo_nxt, neg_res);
                            done_q   <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign div_if.DivStallE  = rst_n && (accept || (state == CALC));
    assign div_if.DivBusyE   = (state != IDLE);
    assign div_if.DivDoneE   = done_q && !div_if.FlushE;
    assign div_if.DivResultE = result_q;
endmodule

// File: doc/execute_div_ctrl.md
Name: execute_div_ctrl

Overview:
- Iterative integer divide sequencer for RV32M DIV/DIVU/REM/REMU in the Execute stage.
- Accepts forwarded operands (SrcA/SrcB after the forwarding muxes) when a divide sits in E.
- Runs a radix-2 restoring divide, one quotient bit per cycle, and holds the front of the pipeline with a stall until the result is ready.
- Its result is muxed onto the E-stage result path alongside the ALU result.

Parameters:
DATA_WIDTH, 32, operand/result width
CNT_WIDTH, $clog2(DATA_WIDTH)+1, iteration counter width

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
StartE  in  1  divide instruction valid in E (decoded, not bubbled)
DivOpE  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
SrcAE  in  DATA_WIDTH  dividend (post-forwarding)
SrcBE  in  DATA_WIDTH  divisor (post-forwarding)
FlushE  in  1  kill the E-stage instruction (branch/jump taken)
DivStallE  out  1  hold F/D/E pipeline registers, bubble into M
DivBusyE  out  1  operation in progress (state != IDLE)
DivDoneE  out  1  one-cycle pulse, DivResultE valid
DivResultE  out  DATA_WIDTH  quotient or remainder (registered)

Behaviour:
- States: IDLE, CALC, DONE. Reset (async, rst_n=0): state=IDLE, counter=0, all internal registers=0. While in reset: DivResultE=0, DivDoneE=0, DivBusyE=0, DivStallE=0.
- IDLE:
  - StartE=1 and FlushE=0 (cycle 0): latch |SrcAE| and |SrcBE| (absolute values for DIV/REM, raw for DIVU/REMU), the op, and the result sign.
  - Quotient sign = sign(A) xor sign(B). Remainder sign = sign(A).
  - Next state: CALC with counter=DATA_WIDTH, or DONE directly for a special case.
- Special cases, resolved in cycle 0, result in cycle 1:
  - Divisor 0: quotient = all ones; remainder = SrcAE unchanged.
  - Signed overflow (A = 0x8000_0000, B = 0xFFFF_FFFF, DIV/REM): quotient = 0x8000_0000; remainder = 0.
- CALC:
  - Each cycle: shift {rem, quo} left by 1; trial-subtract the divisor from rem; on non-negative, keep the difference and set quotient LSB=1.
  - Counter decrements. At counter==1, go to DONE next cycle.
  - Exactly DATA_WIDTH CALC cycles: cycles 1..32 for the default width.
- DONE (cycle DATA_WIDTH+1 = 33):
  - Apply sign correction (two's complement negate if the sign flag is set).
  - DivResultE is registered on entry, so it is valid throughout DONE. DivDoneE=1 for exactly one cycle.
  - Next state is IDLE.
- DivResultE holds its last value until the next completion.
- DivStallE = (state==IDLE & StartE & ~FlushE) | (state==CALC). It is low in DONE, so the divide advances to M at the end of DONE.
  - Total stall: DATA_WIDTH+1 cycles normal, 1 cycle special.
- Back-to-back: after DONE, the next instruction in E may itself have StartE=1; it is accepted in the following IDLE cycle. There are no dead cycles beyond IDLE acceptance.
- FlushE=1 in CALC or DONE: next state IDLE, no DivDoneE pulse, DivResultE unchanged. FlushE in IDLE blocks acceptance.
- Stall/flush from other hazards do not affect the FSM except through FlushE.
- StartE and operand changes while in CALC are ignored; operands are latched.
- Asynchronous reset mid-CALC: immediate IDLE, no done pulse, outputs as listed above.

Decomposition:
- Shared package (riscv_pkg):
  - div_op_t enum (DIV, DIVU, REM, REMU) with the encodings above.
  - div_state_t enum (IDLE, CALC, DONE).
  - DIV_BY_ZERO_Q constant = all ones.
- One natural sub-module: div_iter_core. It holds the shift/subtract datapath registers (rem, quo, divisor) and takes load/step inputs.
- execute_div_ctrl keeps the FSM, counter, sign/special-case logic and output register.

Test Plan:
- DIVU 100/7, StartE at cycle 0 -> DivStallE high cycles 0..32; DivDoneE pulse at cycle 33; DivResultE=14. REMU same operands -> 2.
- DIV -7/2 -> 0xFFFF_FFFD (-3). REM -7/2 -> 0xFFFF_FFFF (-1). REM 7/-2 -> 1.
- DIV 123/0 -> DivDoneE at cycle 1; result 0xFFFF_FFFF; stall only in cycle 0. REMU 123/0 -> 123.
- DIV 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000 at cycle 1. REM with the same operands -> 0.
- DIVU started, FlushE=1 at cycle 10 -> state IDLE at cycle 11, no DivDoneE ever. New DIVU 9/3 with StartE at cycle 11 -> result 3 at cycle 44.
- rst_n pulsed low at cycle 15 of a DIV -> outputs 0 immediately, DivBusyE=0. Back-to-back DIVU 50/5 then REMU 50/6 -> done pulses at cycles 33 and 67 with results 10 and 2.
